abs_sort_stream: RTL and testbench
==================================

# abs_sort_stream

Streaming magnitude sorter for minifloat (or sign-magnitude integer) addends. It collects a batch of up to DEPTH values over a valid/ready input, then emits them largest-|x|-first over a valid/ready output. It sits in front of the accumulators so large addends are summed before small ones. Ordering uses the same exponent-then-mantissa magnitude rule as `abs_bigger_equal`; sign is carried through but ignored for ordering.

## Interface
- `EXP_WIDTH_I`, 5: exponent field width; 0 selects integer (sign-magnitude) mode.
- `MANT_WIDTH_I`, 2: mantissa field width.
- `DEPTH`, 8: maximum batch size, ≥2.
- `BIT_WIDTH_I` (localparam): 1 + `EXP_WIDTH_I` + `MANT_WIDTH_I`.
- `clk_i`, input, 1: clock; single clock domain.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `in_valid_i`, input, 1: input element valid.
- `in_ready_o`, output, 1: sorter accepts input.
- `in_data_i`, input, `BIT_WIDTH_I`: {sign, exp, mant}.
- `in_last_i`, input, 1: final element of batch; qualified by `in_valid_i`.
- `out_valid_o`, output, 1: output element valid.
- `out_ready_i`, input, 1: downstream accepts output.
- `out_data_o`, output, `BIT_WIDTH_I`: sorted element, bit-identical to the input.
- `out_last_o`, output, 1: final element of the sorted batch.

## Operation
- Storage: `buf[0..DEPTH-1]` registers plus `count` (0..DEPTH), kept sorted by descending magnitude at all times.
- FSM states: `S_FILL` and `S_DRAIN`. Reset enters `S_FILL` with `count`=0 and every `buf` entry cleared to 0.
- `S_FILL`:
  - `in_ready_o`=1 and `out_valid_o`=0.
  - On an accepted element, insert it at position p = number of valid entries whose magnitude is ≥ the new value.
  - Entries at p and above shift up by one; `count` increments.
  - Equal magnitudes, including +0/−0, keep arrival order. The new element goes after existing equals, so the sort is stable.
- Fill → drain: the transition happens on accepting an element with `in_last_i`=1, or on the accept that makes `count`=DEPTH, whichever comes first.
- `S_DRAIN`:
  - `in_ready_o`=0 and `out_valid_o`=1.
  - `out_data_o`=`buf[0]`; `out_last_o`=(`count`==1).
  - On handshake, shift the buffer down by one and decrement `count`.
  - When the handshake pops the last element, `count` becomes 0 and the FSM returns to `S_FILL`.
- Input and output never overlap. No input is accepted while draining.
- Magnitude compare:
  - Unsigned compare on the exponent field; on a tie, unsigned compare on the mantissa.
  - No special handling for Inf/NaN encodings; they order by their bit fields.
  - With `EXP_WIDTH_I`=0, the compare uses the mantissa only.
- Reset asserted mid-batch, in either state, discards all contents immediately.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, `out_last_o`=0.
- One insertion per cycle. Inputs can be accepted back-to-back at full rate.
- Latency: `out_valid_o` rises in the cycle after the batch-closing accept.
- Throughput during drain: one element per cycle while `out_ready_i`=1. A batch of N elements costs N fill cycles plus N drain cycles.
- Backpressure: while `out_valid_o`=1 and `out_ready_i`=0, `out_data_o` and `out_last_o` hold stable.
- Return to fill: `in_ready_o` rises in the cycle after the final output handshake.
- All outputs are driven from registers (state, `buf[0]`, `count`). There are no combinational in→out paths.
- The insertion path is one comparator per slot in parallel plus a thermometer-to-position mux. There is no serial compare chain.

## Structure
- Package `abs_sort_pkg`:
  - `typedef enum logic {S_FILL, S_DRAIN} sort_state_e`.
  - `function automatic cnt_width(depth)` returning `$clog2(depth+1)`.
- Sub-module: DEPTH instances of `abs_bigger_equal` (`buf[i]` vs `in_data_i`), producing `ge[i]`.
- `ge[i]` is masked with `i < count`. Because `buf` is sorted, `ge` is a thermometer code, and p = popcount(`ge`).
- Per-slot next value:
  - i < p: keep `buf[i]`.
  - i == p: load `in_data_i`.
  - i > p: load `buf[i-1]`.

## Test plan
Values are E5M2: 0x3C=1.0, 0x40=2.0, 0xC0=−2.0, 0xC4=−4.0, 0x80=−0.

1. Reset, then idle → `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, `out_last_o`=0.
2. Input 0x3C, 0xC4, 0x40, 0x00 (last) on consecutive cycles, `out_ready_i`=1 → output 0xC4, 0x40, 0x3C, 0x00. `out_valid_o` rises the cycle after 0x00 is accepted; `out_last_o` is set only with 0x00.
3. Stability: input 0x40, 0xC0, 0x40, 0x00, 0x80 (last) → output 0x40, 0xC0, 0x40, 0x00, 0x80.
4. Full batch: input 8 distinct values with no last (DEPTH=8) → `in_ready_o`=0 after the 8th accept. Output is 8 values in descending magnitude with `out_last_o` on the 8th; `in_ready_o`=1 the cycle after.
5. Backpressure: hold `out_ready_i`=0 for 5 cycles mid-drain → `out_data_o` and `out_last_o` stable, no element lost or duplicated, `in_ready_o` stays 0.
6. Reset asserted during drain with 3 elements left → next edge `out_valid_o`=0 and `in_ready_o`=1. A new batch 0x3C, 0x40 (last) then outputs 0x40, 0x3C.

Source files
------------

// File: rtl/abs_sort_pkg.sv
// Shared types and helpers for the streaming magnitude sorter.
package abs_sort_pkg;

   typedef enum logic {S_FILL, S_DRAIN} sort_state_e;

   // Counter width able to hold every value 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/abs_bigger_equal.sv
// Magnitude comparator: ge_o = |a| >= |b| for minifloat or sign-magnitude values.
// The caller passes only the magnitude bits {exp, mant}, so the sign never reaches
// the compare. Because the exponent sits above the mantissa, a single unsigned compare
// of the concatenation is the same as comparing the exponent first and then the
// mantissa. With EXP_WIDTH_I=0 the field holds only the mantissa.
module abs_bigger_equal #(
   parameter int EXP_WIDTH_I  = 5,
   parameter int MANT_WIDTH_I = 2,
   localparam int MAG_W       = EXP_WIDTH_I + MANT_WIDTH_I
) (
   input  logic [MAG_W-1:0] a_mag_i,
   input  logic [MAG_W-1:0] b_mag_i,
   output logic             ge_o
);

   assign ge_o = (a_mag_i >= b_mag_i);

endmodule

// File: rtl/abs_sort_stream.sv
// Streaming magnitude sorter: collects a batch of up to DEPTH elements, keeping
// them sorted by descending magnitude on every insert, then drains the batch
// largest-first. Equal magnitudes keep their arrival order.
module abs_sort_stream
   import abs_sort_pkg::*;
#(
   parameter int EXP_WIDTH_I  = 5,
   parameter int MANT_WIDTH_I = 2,
   parameter int DEPTH        = 8,
   localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [BIT_WIDTH_I-1:0] in_data_i,
   input  logic                   in_last_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [BIT_WIDTH_I-1:0] out_data_o,
   output logic                   out_last_o
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int MAG_W = BIT_WIDTH_I - 1;

   sort_state_e            state_reg;
   logic [CNT_W-1:0]       count_reg;
   logic                   in_ready_reg;
   logic                   out_valid_reg;
   logic                   out_last_reg;

   logic [BIT_WIDTH_I-1:0] buf_reg   [DEPTH];
   logic [BIT_WIDTH_I-1:0] buf_next  [DEPTH];
   logic [BIT_WIDTH_I-1:0] buf_shift [DEPTH];

   logic [DEPTH-1:0]       ge;
   logic [DEPTH-1:0]       ge_masked;
   logic [CNT_W-1:0]       pos;

   logic                   accept;
   logic                   pop;

   assign accept = in_valid_i && (state_reg == S_FILL);
   assign pop    = out_ready_i && (state_reg == S_DRAIN);

   // One comparator per slot, all in parallel. Only occupied slots take part, so
   // with a sorted buffer the masked vector is a thermometer code.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         abs_bigger_equal #(
            .EXP_WIDTH_I  (EXP_WIDTH_I),
            .MANT_WIDTH_I (MANT_WIDTH_I)
         ) u_cmp (
            .a_mag_i (buf_reg[gi][MAG_W-1:0]),
            .b_mag_i (in_data_i[MAG_W-1:0]),
            .ge_o    (ge[gi])
         );

         assign ge_masked[gi] = ge[gi] && (CNT_W'(gi) < count_reg);

         // Insert: keep slots ahead of the insertion point, load the new element at
         // it, and move everything behind it up by one slot.
         if (gi == 0) begin : g_first
            assign buf_next[gi] = (pos == '0) ? in_data_i : buf_reg[gi];
         end else begin : g_rest
            assign buf_next[gi] = (CNT_W'(gi) < pos)  ? buf_reg[gi]  :
                                  (CNT_W'(gi) == pos) ? in_data_i    :
                                                        buf_reg[gi-1];
         end

         // Pop: everything moves down by one, the top slot empties.
         if (gi == DEPTH - 1) begin : g_top
            assign buf_shift[gi] = '0;
         end else begin : g_below
            assign buf_shift[gi] = buf_reg[gi+1];
         end
      end
   endgenerate

   // Insertion point = number of occupied entries with magnitude >= the new one.
   always_comb begin
      pos = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pos = pos + CNT_W'(ge_masked[i]);
      end
   end

   // Element storage: cleared on reset, shifted on insert or pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_reg[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_reg[i] <= buf_next[i];
         end
      end else if (pop) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_reg[i] <= buf_shift[i];
         end
      end
   end

   // Fill/drain FSM with occupancy count and registered handshake flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= S_FILL;
         count_reg     <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else begin
         case (state_reg)
            S_FILL: begin
               if (in_valid_i) begin
                  count_reg <= count_reg + CNT_W'(1);
                  // Batch closes on an explicit last or when the buffer becomes full.
                  if (in_last_i || (count_reg == CNT_W'(DEPTH - 1))) begin
                     state_reg     <= S_DRAIN;
                     in_ready_reg  <= 1'b0;
                     out_valid_reg <= 1'b1;
                     out_last_reg  <= (count_reg == '0);
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready_i) begin
                  count_reg <= count_reg - CNT_W'(1);
                  if (count_reg == CNT_W'(1)) begin
                     state_reg     <= S_FILL;
                     in_ready_reg  <= 1'b1;
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                  end else begin
                     out_last_reg  <= (count_reg == CNT_W'(2));
                  end
               end
            end
            default: begin
               state_reg <= S_FILL;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_reg;
   assign out_valid_o = out_valid_reg;
   assign out_data_o  = buf_reg[0];
   assign out_last_o  = out_last_reg;

endmodule

// File: tb/tb_abs_sort_stream.sv
// Self-checking bench for abs_sort_stream: directed E5M2 cases plus randomized
// batches compared against a stable selection-sort reference model.
module tb_abs_sort_stream;

   localparam int DEPTH = 8;
   localparam int W     = 8;

   typedef logic [W-1:0] elem_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   elem_t         in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   elem_t         out_data;
   logic          out_last;

   int            total = 0;
   int            bad   = 0;

   abs_sort_stream #(
      .EXP_WIDTH_I  (5),
      .MANT_WIDTH_I (2),
      .DEPTH        (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_last_i   (in_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: repeatedly take the first element of largest magnitude (sign ignored).
   // Picking the first occurrence on ties gives the stable order.
   task automatic ref_sort(input elem_t src[$], output elem_t dst[$]);
      elem_t tmp[$];
      int    best;
      tmp = src;
      dst = {};
      while (tmp.size() > 0) begin
         best = 0;
         for (int i = 1; i < tmp.size(); i++) begin
            if (tmp[i][W-2:0] > tmp[best][W-2:0]) best = i;
         end
         dst.push_back(tmp[best]);
         tmp.delete(best);
      end
   endtask

   // Called one time unit after a rising edge; drives one element for one cycle.
   task automatic push(input elem_t d, input logic last);
      check("fill_in_ready", in_ready, 1'b1);
      check("fill_out_valid", out_valid, 1'b0);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk);
      #1;
      $display("push data=0x%02h last=%0b", d, last);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic send_batch(input elem_t vals[$], input logic use_last);
      for (int i = 0; i < vals.size(); i++) begin
         push(vals[i], use_last && (i == vals.size() - 1));
      end
      check("drain_rise_valid", out_valid, 1'b1);
      check("drain_in_ready", in_ready, 1'b0);
   endtask

   // Pops n_take elements, optionally stalling stall_len cycles before element stall_at.
   task automatic drain(input elem_t exp_q[$], input int n_take, input int stall_at,
                        input int stall_len);
      elem_t hold_d;
      logic  hold_l;
      int    waited;
      for (int k = 0; k < n_take; k++) begin
         waited = 0;
         while (!out_valid && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
         end
         if (!out_valid) begin
            check("drain_timeout", 32'd0, 32'd1);
            out_ready = 1'b0;
            return;
         end
         if (k == stall_at) begin
            out_ready = 1'b0;
            hold_d    = out_data;
            hold_l    = out_last;
            for (int s = 0; s < stall_len; s++) begin
               @(posedge clk);
               #1;
               check("bp_data", out_data, hold_d);
               check("bp_last", out_last, hold_l);
               check("bp_valid", out_valid, 1'b1);
               check("bp_in_ready", in_ready, 1'b0);
            end
         end
         out_ready = 1'b1;
         check($sformatf("out_data[%0d]", k), out_data, exp_q[k]);
         check($sformatf("out_last[%0d]", k), out_last, (k == exp_q.size() - 1));
         $display("pop  data=0x%02h last=%0b expect=0x%02h", out_data, out_last, exp_q[k]);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      if (n_take == exp_q.size()) begin
         check("refill_in_ready", in_ready, 1'b1);
         check("refill_out_valid", out_valid, 1'b0);
      end
   endtask

   initial begin
      elem_t vals[$];
      elem_t exp_q[$];
      elem_t pool[6];
      int    len;
      logic  use_last;

      pool = '{8'h00, 8'h80, 8'h3C, 8'hBC, 8'h40, 8'hC0};

      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset state while idle.
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_last", out_last, 1'b0);

      // Basic ordering with mixed signs.
      vals  = '{8'h3C, 8'hC4, 8'h40, 8'h00};
      exp_q = '{8'hC4, 8'h40, 8'h3C, 8'h00};
      send_batch(vals, 1'b1);
      drain(exp_q, exp_q.size(), -1, 0);

      // Stability for equal magnitudes, including +0/-0.
      vals  = '{8'h40, 8'hC0, 8'h40, 8'h00, 8'h80};
      exp_q = '{8'h40, 8'hC0, 8'h40, 8'h00, 8'h80};
      send_batch(vals, 1'b1);
      drain(exp_q, exp_q.size(), -1, 0);

      // Full batch closes without last; backpressure mid-drain.
      vals  = '{8'h01, 8'h44, 8'hBC, 8'h7B, 8'h3D, 8'h82, 8'hC8, 8'h20};
      exp_q = '{8'h7B, 8'hC8, 8'h44, 8'h3D, 8'hBC, 8'h20, 8'h82, 8'h01};
      send_batch(vals, 1'b0);
      drain(exp_q, exp_q.size(), 3, 5);

      // Reset during drain with three elements left.
      vals = '{8'h3C, 8'h40, 8'hC4, 8'h01, 8'h02};
      ref_sort(vals, exp_q);
      send_batch(vals, 1'b1);
      drain(exp_q, 2, -1, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_data", out_data, 8'h00);
      check("midrst_out_last", out_last, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vals  = '{8'h3C, 8'h40};
      exp_q = '{8'h40, 8'h3C};
      send_batch(vals, 1'b1);
      drain(exp_q, exp_q.size(), -1, 0);

      // Randomized batches, with ties and random stalls.
      for (int b = 0; b < 40; b++) begin
         len  = $urandom_range(1, DEPTH);
         vals = {};
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) vals.push_back(pool[$urandom_range(0, 5)]);
            else                          vals.push_back(elem_t'($urandom_range(0, 255)));
         end
         use_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
         ref_sort(vals, exp_q);
         send_batch(vals, use_last);
         if ($urandom_range(0, 3) == 0) drain(exp_q, exp_q.size(), $urandom_range(0, len - 1), $urandom_range(1, 4));
         else                           drain(exp_q, exp_q.size(), -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
